// File: rtl/adc_frame_sequencer.sv
// Per-frame pixel readout sequencer: steps each pixel through reset, sample and
// conversion phases, captures the ADC count and hands it out over valid/ready.
module adc_frame_sequencer #(
  parameter int PIXELS   = 16,
  parameter int RST_CYC  = 4,
  parameter int SMP_CYC  = 8,
  parameter int CONV_CYC = 16,
  parameter int ADC_W    = 4,
  localparam int AW      = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic             abort,
  input  logic [ADC_W-1:0] adc_count,
  output logic             S1,
  output logic             S2bar,
  output logic             S3,
  output logic             adc_enable,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [ADC_W-1:0] pix_data,
  output logic [AW-1:0]    pix_addr,
  output logic             busy,
  output logic             eof,
  output logic [15:0]      frame_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_SMP  = 3'd2;
  localparam logic [2:0] S_CONV = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;
  localparam logic [2:0] S_EOF  = 3'd5;

  localparam int CMAX_A = (RST_CYC > SMP_CYC) ? RST_CYC : SMP_CYC;
  localparam int CMAX   = (CMAX_A > CONV_CYC) ? CMAX_A : CONV_CYC;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

  logic [2:0]       state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [ADC_W-1:0] data_reg, data_next;
  logic [15:0]      frame_reg, frame_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    addr_next  = addr_reg;
    data_next  = data_reg;
    frame_next = frame_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (start && !abort) begin
          state_next = S_RST;
          addr_next  = '0;
        end
      end
      S_RST: begin
        if (cnt_reg == CW'(RST_CYC - 1)) begin
          state_next = S_SMP;
          cnt_next   = '0;
        end
      end
      S_SMP: begin
        if (cnt_reg == CW'(SMP_CYC - 1)) begin
          state_next = S_CONV;
          cnt_next   = '0;
        end
      end
      S_CONV: begin
        if (cnt_reg == CW'(CONV_CYC - 1)) begin
          state_next = S_OUT;
          cnt_next   = '0;
          data_next  = adc_count;
        end
      end
      S_OUT: begin
        cnt_next = '0;
        if (pix_ready) begin
          if (addr_reg == AW'(PIXELS - 1)) begin
            state_next = S_EOF;
          end else begin
            state_next = S_RST;
            addr_next  = addr_reg + AW'(1);
          end
        end
      end
      S_EOF: begin
        cnt_next   = '0;
        frame_next = frame_reg + 16'd1;
        state_next = S_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase

    // Abort overrides every transition, including a same-cycle handshake or EOF.
    if (abort && state_reg != S_IDLE) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      addr_next  = '0;
      data_next  = data_reg;
      frame_next = frame_reg;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      frame_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      frame_reg <= frame_next;
    end
  end

  // Outputs decode only registered state, so reset takes effect without a clock.
  assign S1         = (state_reg == S_RST);
  assign S2bar      = (state_reg != S_SMP);
  assign S3         = (state_reg == S_SMP);
  assign adc_enable = (state_reg == S_CONV);
  assign pix_valid  = (state_reg == S_OUT);
  assign eof        = (state_reg == S_EOF);
  assign busy       = (state_reg != S_IDLE);
  assign pix_addr   = addr_reg;
  assign pix_data   = data_reg;
  assign frame_cnt  = frame_reg;

endmodule

// File: tb/tb_adc_frame_sequencer.sv
// Self-checking bench for adc_frame_sequencer: a timing table for one frame,
// directed multi-cycle corner cases, then random traffic against a reference model.
module tb_adc_frame_sequencer;

  localparam int P = 16, R = 4, S = 8, C = 16;
  localparam int LEN = R + S + C;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0, abort = 1'b0, pix_ready = 1'b1;
  logic [3:0] adc_count = 4'h0;
  logic       S1, S2bar, S3, adc_enable, pix_valid, busy, eof;
  logic [3:0] pix_data, pix_addr;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  adc_frame_sequencer #(.PIXELS(P), .RST_CYC(R), .SMP_CYC(S), .CONV_CYC(C), .ADC_W(4)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .abort(abort), .adc_count(adc_count),
    .S1(S1), .S2bar(S2bar), .S3(S3), .adc_enable(adc_enable), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_data(pix_data), .pix_addr(pix_addr), .busy(busy),
    .eof(eof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] exp;
  } vec_t;

  vec_t tab[12];

  function automatic logic [31:0] pack(input logic s1, s2b, s3, en, v, e, b,
                                       input int addr, data, fc);
    return {1'b0, s1, s2b, s3, en, v, e, b, 4'(addr), 4'(data), 16'(fc)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {1'b0, S1, S2bar, S3, adc_enable, pix_valid, eof, busy, pix_addr, pix_data, frame_cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: pixel index plus elapsed cycles within the pixel.
  int          m_mode;   // 0 idle, 1 inside a pixel, 2 end-of-frame cycle
  int          m_pix, m_t, m_frames;
  logic [3:0]  m_data;

  function automatic logic [31:0] model_vec();
    logic s1, s3, en, v;
    s1 = 0; s3 = 0; en = 0; v = 0;
    if (m_mode == 1) begin
      if (m_t < R) s1 = 1;
      else if (m_t < R + S) s3 = 1;
      else if (m_t < LEN) en = 1;
      else v = 1;
    end
    return pack(s1, !s3, s3, en, v, m_mode == 2, m_mode != 0, m_pix, int'(m_data), m_frames);
  endfunction

  task automatic model_step();
    if (m_mode != 0 && abort) begin
      m_mode = 0;
      m_pix  = 0;
    end else if (m_mode == 0) begin
      if (start && !abort) begin
        m_mode = 1; m_pix = 0; m_t = 0;
      end
    end else if (m_mode == 1) begin
      if (m_t < LEN) begin
        if (m_t == LEN - 1) m_data = adc_count;
        m_t++;
      end else if (pix_ready) begin
        if (m_pix == P - 1) m_mode = 2;
        else begin
          m_pix++; m_t = 0;
        end
      end
    end else begin
      m_frames = (m_frames + 1) % 65536;
      m_mode   = 0;
    end
  endtask

  initial begin
    int cyc, n, eofs;
    logic [3:0] held;

    tab[0]  = '{0,   pack(0,1,0,0,0,0,0, 0, 0,   0)};
    tab[1]  = '{1,   pack(1,1,0,0,0,0,1, 0, 0,   0)};
    tab[2]  = '{4,   pack(1,1,0,0,0,0,1, 0, 0,   0)};
    tab[3]  = '{5,   pack(0,0,1,0,0,0,1, 0, 0,   0)};
    tab[4]  = '{12,  pack(0,0,1,0,0,0,1, 0, 0,   0)};
    tab[5]  = '{13,  pack(0,1,0,1,0,0,1, 0, 0,   0)};
    tab[6]  = '{28,  pack(0,1,0,1,0,0,1, 0, 0,   0)};
    tab[7]  = '{29,  pack(0,1,0,0,1,0,1, 0, 'hA, 0)};
    tab[8]  = '{30,  pack(1,1,0,0,0,0,1, 1, 'hA, 0)};
    tab[9]  = '{464, pack(0,1,0,0,1,0,1, 15,'hA, 0)};
    tab[10] = '{465, pack(0,1,0,0,0,1,1, 15,'hA, 0)};
    tab[11] = '{466, pack(0,1,0,0,0,0,0, 15,'hA, 1)};

    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    chk("reset_state", dut_vec(), pack(0,1,0,0,0,0,0, 0, 0, 0));

    // Full frame timing with pix_ready high and a constant ADC count.
    adc_count = 4'hA;
    pix_ready = 1'b1;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      while (cyc < tab[i].cyc) begin
        tick();
        cyc++;
        start = 1'b0;
      end
      chk($sformatf("frame_cyc%0d", tab[i].cyc), dut_vec(), tab[i].exp);
      if (cyc == 0) start = 1'b1;
    end
    $display("frame 1: timing table done at cycle %0d", cyc);

    // Back-pressure on pixel 3, then abort during pixel 7 conversion.
    adc_count = 4'h5;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(pix_valid && pix_addr == 4'd3) && n < LIMIT) begin tick(); n++; end
    chk("wait_pix3_out", 32'(n < LIMIT), 32'd1);
    pix_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("hold_pix3_k%0d", k), dut_vec(), pack(0,1,0,0,1,0,1, 3, 5, 1));
      tick();
    end
    chk("hold_pix3_last", dut_vec(), pack(0,1,0,0,1,0,1, 3, 5, 1));
    pix_ready = 1'b1;
    tick();
    chk("pix4_rst_after_ready", dut_vec(), pack(1,1,0,0,0,0,1, 4, 5, 1));
    $display("frame 2: pixel 3 held 10 cycles");

    n = 0;
    while (!(adc_enable && pix_addr == 4'd7) && n < LIMIT) begin tick(); n++; end
    chk("wait_pix7_conv", 32'(n < LIMIT), 32'd1);
    adc_count = 4'h9;
    repeat (4) tick();
    abort = 1'b1;
    pix_ready = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_to_idle", dut_vec(), pack(0,1,0,0,0,0,0, 0, 5, 1));
    tick();
    chk("abort_stays_idle", dut_vec(), pack(0,1,0,0,0,0,0, 0, 5, 1));
    $display("frame 2: aborted in pixel 7 conversion");

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", dut_vec(), pack(0,1,0,0,0,0,0, 0, 5, 1));

    // Ramp the ADC across the first conversion window of a new frame.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!adc_enable && n < LIMIT) begin tick(); n++; end
    chk("wait_ramp_conv", 32'(n < LIMIT), 32'd1);
    for (int k = 0; k < C; k++) begin
      adc_count = 4'(k);
      tick();
    end
    adc_count = 4'h2;
    chk("ramp_capture", dut_vec(), pack(0,1,0,0,1,0,1, 0, 15, 1));

    // Finish this frame while hammering start; exactly one eof expected.
    eofs = 0;
    n = 0;
    while (busy && n < LIMIT) begin
      if (eof) begin
        eofs++;
        start = 1'b0;
      end else begin
        start = ~start;
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("busy_start_timeout", 32'(n < LIMIT), 32'd1);
    chk("busy_start_eofs", 32'(eofs), 32'd1);
    held = pix_data;
    chk("frame3_end", dut_vec(), pack(0,1,0,0,0,0,0, 15, int'(held), 2));
    chk("frame3_data_last", 32'(held), 32'h2);
    $display("frame 3: ramp capture and start-while-busy done, eofs=%0d", eofs);

    // Asynchronous reset in the middle of the sample phase.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!S3 && n < LIMIT) begin tick(); n++; end
    chk("wait_smp", 32'(n < LIMIT), 32'd1);
    chk("in_smp", dut_vec(), pack(0,0,1,0,0,0,1, 0, 2, 2));
    #2 n_reset = 1'b0;
    #1 chk("async_reset", dut_vec(), pack(0,1,0,0,0,0,0, 0, 0, 0));
    @(negedge clk);
    chk("reset_held", dut_vec(), pack(0,1,0,0,0,0,0, 0, 0, 0));
    n_reset = 1'b1;
    $display("async reset during sample phase done");

    // Random traffic against the reference model.
    m_mode = 0; m_pix = 0; m_t = 0; m_frames = 0; m_data = 4'h0;
    for (int k = 0; k < 6000; k++) begin
      chk($sformatf("random_cyc%0d", k), dut_vec(), model_vec());
      start     = ($urandom % 20) == 0;
      abort     = ($urandom % 1500) == 0;
      pix_ready = ($urandom % 4) != 0;
      adc_count = 4'($urandom);
      @(posedge clk);
      model_step();
      if (m_mode == 2) $display("random: frame end, model frame count %0d", m_frames + 1);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
